// File: rtl/rr_stream_arbiter.sv
// rtl/rr_stream_arbiter.sv - round-robin N:1 stream arbiter with one registered output stage
// Optional packet lock (grant held from first beat until in_last) enabled by `define ARB_PKT_LOCK_EN.
module rr_stream_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4,
   parameter int IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            in_valid,
   output logic [NUM_REQ-1:0]            in_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_REQ-1:0]            in_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [IDX_W-1:0]              out_src,
   output logic                          out_last
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   logic                 stage_rdy;
   logic                 grant_any;
   logic [IDX_W-1:0]     grant_idx;
   logic [NUM_REQ-1:0]   grant;
   logic                 accept;
   logic [IDX_W-1:0]     rr_ptr;
   logic [IDX_W-1:0]     next_ptr;
   int                   cand;

`ifdef ARB_PKT_LOCK_EN
   logic                 lock;
   logic [IDX_W-1:0]     lock_idx;
`endif

   // The stage can take a new beat when it is empty or its beat leaves this cycle.
   assign stage_rdy = ~out_valid | out_ready;

   // Rotating priority search; walking from farthest to nearest so the nearest valid wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (in_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand[IDX_W-1:0];
         end
      end
`ifdef ARB_PKT_LOCK_EN
      // A packet in flight owns the stage, even across bubbles in its valid.
      if (lock) begin
         grant_any = 1'b1;
         grant_idx = lock_idx;
      end
`endif
   end

   // One-hot grant vector gated by stage readiness; nobody is ready during reset.
   always_comb begin
      grant = '0;
      if (grant_any) begin
         grant[grant_idx] = 1'b1;
      end
      in_ready = grant & {NUM_REQ{stage_rdy & rst_n}};
   end

   assign accept   = grant_any & in_valid[grant_idx] & stage_rdy;
   assign next_ptr = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);

   // Output register: load on accept, clear valid on drain, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= in_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
         out_src   <= grant_idx;
         out_last  <= in_last[grant_idx];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Round-robin pointer moves just past the requester that was served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
`ifdef ARB_PKT_LOCK_EN
      end else if (accept && in_last[grant_idx]) begin
`else
      end else if (accept) begin
`endif
         rr_ptr <= next_ptr;
      end
   end

`ifdef ARB_PKT_LOCK_EN
   // Lock engages on a non-final beat and releases when the final beat is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock     <= 1'b0;
         lock_idx <= '0;
      end else if (accept) begin
         lock     <= ~in_last[grant_idx];
         lock_idx <= grant_idx;
      end
   end
`endif

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb/tb_rr_stream_arbiter.sv - self-checking bench for rr_stream_arbiter (NUM_REQ=4, DATA_WIDTH=8)
module tb_rr_stream_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    in_valid = '0;
   logic [N-1:0]    in_ready;
   logic [N*DW-1:0] in_data = '0;
   logic [N-1:0]    in_last = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [DW-1:0]   out_data;
   logic [1:0]      out_src;
   logic            out_last;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0] v;
      logic       r;
      logic [3:0] rdy;
      logic       ov;
      int         src;
   } vec_t;

   vec_t tbl[16];

   rr_stream_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_src(out_src), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic std_data();
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 8'(8'hA0 + i);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Called at posedge+1: drive, check ready before the edge, then check outputs after it.
   task automatic step(input string nm, input logic [3:0] v, input logic r, input logic [3:0] exp_rdy,
                       input logic exp_ov, input int exp_src);
      in_valid = v; out_ready = r;
      #1 chk({nm, " in_ready"}, in_ready, exp_rdy);
      @(posedge clk); #1;
      chk({nm, " out_valid"}, out_valid, exp_ov);
      if (exp_ov) begin
         chk({nm, " out_src"}, out_src, exp_src);
         chk({nm, " out_data"}, out_data, in_data[exp_src*DW +: DW]);
         chk({nm, " out_last"}, out_last, in_last[exp_src]);
      end
   endtask

   // Random stimulus against a rotating-priority reference model.
   task automatic random_run(input int cycles);
      int         m_ptr = 0;
      bit         m_ov = 0;
      bit [1:0]   m_src = 0;
      bit [7:0]   m_dat = 0;
      bit         m_last = 0;
      bit         m_lock = 0;
      int         m_lidx = 0;
      do_reset();
      for (int c = 0; c < cycles; c++) begin
         int       w;
         bit       srdy, acc;
         bit [3:0] exp_rdy;
         in_valid  = 4'($urandom_range(0, 15));
         in_last   = 4'($urandom_range(0, 15));
         in_data   = 32'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         srdy = !m_ov || out_ready;
         w = -1;
         if (m_lock) w = m_lidx;
         else
            for (int k = 0; k < N; k++)
               if (w < 0 && in_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         exp_rdy = (w >= 0 && srdy) ? 4'(1 << w) : 4'b0;
         acc = (w >= 0) && srdy && in_valid[w];
         #1 chk("rand in_ready", in_ready, exp_rdy);
         if (acc) begin
            m_ov = 1; m_src = 2'(w); m_dat = in_data[w*DW +: DW]; m_last = in_last[w];
`ifdef ARB_PKT_LOCK_EN
            m_lock = !in_last[w]; m_lidx = w;
            if (in_last[w]) m_ptr = (w + 1) % N;
`else
            m_ptr = (w + 1) % N;
`endif
         end else if (out_ready) begin
            m_ov = 0;
         end
         @(posedge clk); #1;
         chk("rand out_valid", out_valid, m_ov);
         if (m_ov) begin
            chk("rand out_src", out_src, m_src);
            chk("rand out_data", out_data, m_dat);
            chk("rand out_last", out_last, m_last);
         end
      end
   endtask

   initial begin
      tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0};
      tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1};
      tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2};
      tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3};
      tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0};
      tbl[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2};
      tbl[6]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2};
      tbl[7]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2};
      tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0};
      tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 0};
      tbl[10] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 0};
      tbl[11] = '{4'b1001, 1'b0, 4'b0000, 1'b1, 0};
      tbl[12] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 3};
      tbl[13] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 0};
      tbl[14] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 0};
      tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0};

      // Reset state and idle
      do_reset();
      chk("reset out_data", out_data, 8'h00);
      chk("reset out_last", out_last, 1'b0);
      for (int i = 0; i < 10; i++) begin
         #1 chk("idle in_ready", in_ready, 4'b0000);
         @(posedge clk); #1;
         chk("idle out_valid", out_valid, 1'b0);
         chk("idle out_src", out_src, 2'd0);
      end

      // Table of per-beat arbitration vectors
      do_reset();
      std_data();
      in_last = 4'b1111;
      for (int i = 0; i < 16; i++)
         step($sformatf("tbl[%0d]", i), tbl[i].v, tbl[i].r, tbl[i].rdy, tbl[i].ov, tbl[i].src);

      // Single requester gets every cycle
      in_data[2*DW +: DW] = 8'h55;
      for (int i = 0; i < 4; i++) step("single req2", 4'b0100, 1'b1, 4'b0100, 1'b1, 2);

      // Backpressure freezes the stage, then the pointer resumes past req1
      do_reset();
      std_data();
      step("bp accept req1", 4'b0010, 1'b0, 4'b0010, 1'b1, 1);
      for (int i = 0; i < 3; i++) step("bp hold", 4'b1001, 1'b0, 4'b0000, 1'b1, 1);
      step("bp release req3", 4'b1001, 1'b1, 4'b1000, 1'b1, 3);
      step("bp then req0", 4'b1001, 1'b1, 4'b0001, 1'b1, 0);

      // Asynchronous reset mid-stream
      in_valid = 4'b1111; out_ready = 1'b0;
      @(posedge clk); #1 chk("pre-rst out_valid", out_valid, 1'b1);
      #3 rst_n = 1'b0;
      #1 chk("async rst out_valid", out_valid, 1'b0);
      chk("async rst in_ready", in_ready, 4'b0000);
      @(posedge clk); #1 rst_n = 1'b1;
      step("post-rst lowest", 4'b0110, 1'b1, 4'b0010, 1'b1, 1);

`ifdef ARB_PKT_LOCK_EN
      // Packet lock: req0 holds the stage through a bubble until its last beat
      do_reset();
      std_data();
      in_last = 4'b0000;
      step("lock beat1", 4'b0011, 1'b1, 4'b0001, 1'b1, 0);
      step("lock beat2", 4'b0011, 1'b1, 4'b0001, 1'b1, 0);
      step("lock bubble", 4'b0010, 1'b1, 4'b0001, 1'b0, 0);
      in_last = 4'b0001;
      step("lock beat3", 4'b0011, 1'b1, 4'b0001, 1'b1, 0);
      in_last = 4'b0000;
      step("lock release", 4'b0010, 1'b1, 4'b0010, 1'b1, 1);
`endif

      random_run(400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
